// File: rtl/mem_port_arbiter_if.sv
// Pipeline-side request/response and memory-macro signals of the shared memory port.
// The arbiter uses the slave modport; the pipeline/memory environment uses the master modport.
interface mem_port_arbiter_if #(
    parameter int AW = 5
);
    logic          if_req;
    logic [31:0]   if_addr;
    logic [31:0]   if_rdata;
    logic          if_ack;
    logic          dm_req;
    logic          dm_we;
    logic [3:0]    dm_be;
    logic [31:0]   dm_addr;
    logic [31:0]   dm_wdata;
    logic [31:0]   dm_rdata;
    logic          dm_ack;
    logic          mem_en;
    logic          mem_we;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic          stall;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_be, dm_addr, dm_wdata, mem_rdata,
        output if_rdata, if_ack, dm_rdata, dm_ack,
        output mem_en, mem_we, mem_be, mem_addr, mem_wdata, stall
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_be, dm_addr, dm_wdata, mem_rdata,
        input  if_rdata, if_ack, dm_rdata, dm_ack,
        input  mem_en, mem_we, mem_be, mem_addr, mem_wdata, stall
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported synchronous memory between instruction fetch and data access.
// Optional fetch anti-starvation guard: define ARB_FETCH_GUARD_EN.
module mem_port_arbiter #(
    parameter int AW         = 5,
    parameter int MEM_LAT    = 1,
    parameter int MAX_DBURST = 4
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);
    localparam int CW = $clog2(MEM_LAT + 1);
    localparam int BW = $clog2(MAX_DBURST + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    state_t        state_q, state_d;
    logic          owner_dm_q, owner_dm_d;
    logic [CW-1:0] lat_q, lat_d;
    logic [BW-1:0] burst_q, burst_d;
    logic          pick_dm;

    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [3:0]    mem_be_q, mem_be_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic [31:0]   if_rdata_q, if_rdata_d;
    logic [31:0]   dm_rdata_q, dm_rdata_d;

    logic          unused_addr_bits;
    assign unused_addr_bits = ^{bus.if_addr[31:AW+2], bus.if_addr[1:0],
                                bus.dm_addr[31:AW+2], bus.dm_addr[1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            owner_dm_q  <= 1'b0;
            lat_q       <= '0;
            burst_q     <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_dm_q  <= owner_dm_d;
            lat_q       <= lat_d;
            burst_q     <= burst_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    // Data wins a tie (it belongs to the older instruction) unless the guard forces a fetch turn.
    always_comb begin
        pick_dm = bus.dm_req;
`ifdef ARB_FETCH_GUARD_EN
        if (bus.if_req && (burst_q >= BW'(MAX_DBURST)))
            pick_dm = 1'b0;
`endif
    end

    always_comb begin
        state_d    = state_q;
        owner_dm_d = owner_dm_q;
        lat_d      = lat_q;
        burst_d    = burst_q;
        case (state_q)
            IDLE: begin
                if (bus.if_req || bus.dm_req) begin
                    state_d    = ACCESS;
                    owner_dm_d = pick_dm;
                    // Saturating count of data grants that made a waiting fetch step aside.
                    if (!pick_dm)
                        burst_d = '0;
                    else if (bus.if_req && (burst_q != BW'(MAX_DBURST)))
                        burst_d = burst_q + 1'b1;
                end
            end
            ACCESS: begin
                state_d = WAIT;
                lat_d   = CW'(MEM_LAT);
            end
            WAIT: begin
                lat_d = lat_q - 1'b1;
                if (lat_q == CW'(1))
                    state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Memory strobes are precomputed so the registered outputs are live exactly in ACCESS.
    always_comb begin
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_be_d    = '0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if (state_d == ACCESS) begin
            mem_en_d = 1'b1;
            if (owner_dm_d) begin
                mem_we_d    = bus.dm_we;
                mem_be_d    = bus.dm_be;
                mem_addr_d  = bus.dm_addr[AW+1:2];
                mem_wdata_d = bus.dm_wdata;
            end else begin
                mem_addr_d  = bus.if_addr[AW+1:2];
            end
        end
        if ((state_q == WAIT) && (lat_q == CW'(1))) begin
            if (owner_dm_q)
                dm_rdata_d = bus.mem_rdata;
            else
                if_rdata_d = bus.mem_rdata;
        end
    end

    assign bus.if_ack    = (state_q == RESP) && !owner_dm_q;
    assign bus.dm_ack    = (state_q == RESP) &&  owner_dm_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.stall     = (bus.if_req & ~bus.if_ack) | (bus.dm_req & ~bus.dm_ack);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction-level model plus directed vectors.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    localparam int AW   = 5;
    localparam int LAT  = 1;
    localparam int LAT3 = 3;
    localparam int MAXB = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(AW)) bus ();
    mem_port_arbiter_if #(.AW(AW)) bus3 ();

    mem_port_arbiter #(.AW(AW), .MEM_LAT(LAT), .MAX_DBURST(MAXB)) u_dut (
        .clk(clk), .rst(rst), .bus(bus));
    mem_port_arbiter #(.AW(AW), .MEM_LAT(LAT3), .MAX_DBURST(MAXB)) u_dut3 (
        .clk(clk), .rst(rst), .bus(bus3));

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_s(input string nm, input string act, input string exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %s want %s", nm, act, exp);
        end
    endtask

    // Memory macro for the main DUT: read data held from the cycle after mem_en.
    function automatic logic [31:0] init_val(input int i);
        return (i == 2) ? 32'h0050_0093 : (32'hD000_0000 | 32'(i));
    endfunction

    logic [31:0] mem [0:(1<<AW)-1];
    bit          mem_ready = 1'b0;
    logic [31:0] rd_q = '0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < (1<<AW); i++) mem[i] <= init_val(i);
            mem_ready <= 1'b1;
        end else if (bus.mem_en) begin
            if (bus.mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (bus.mem_be[b]) mem[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            end else begin
                rd_q <= mem[bus.mem_addr];
            end
        end
    end
    assign bus.mem_rdata = rd_q;

    logic [31:0] rd3_q = '0;
    always @(posedge clk) if (bus3.mem_en) rd3_q <= 32'hA5A5_0000 | 32'(bus3.mem_addr);
    assign bus3.mem_rdata = rd3_q;

    // Transaction model: a grant at sample cycle g puts the access on the memory in g+1,
    // captures at the end of g+LAT+1, acks in g+LAT+2 and samples again from g+LAT+3.
    int          g_cyc = -100;
    int          free_cyc = 0;
    bit          g_dm = 1'b0, g_we = 1'b0;
    logic [3:0]  g_be = '0;
    logic [AW-1:0] g_addr = '0;
    logic [31:0] g_wdata = '0, g_rdata = '0;
    logic [31:0] e_if_rd = '0, e_dm_rd = '0;
    bit          dm_rd_known = 1'b1;
    int          burst = 0;
`ifdef ARB_FETCH_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            g_cyc = -100; free_cyc = 0; burst = 0;
            e_if_rd = '0; e_dm_rd = '0; dm_rd_known = 1'b1;
        end else begin
            if (cyc == g_cyc + LAT + 1) begin
                if (g_dm) begin e_dm_rd = g_rdata; dm_rd_known = !g_we; end
                else e_if_rd = g_rdata;
            end
            if (cyc >= free_cyc && (bus.if_req || bus.dm_req)) begin
                g_dm = bus.dm_req && !(GUARD && bus.if_req && burst >= MAXB);
                if (!g_dm) burst = 0;
                else if (bus.if_req && burst < MAXB) burst++;
                g_cyc = cyc; free_cyc = cyc + LAT + 3;
                g_we    = g_dm && bus.dm_we;
                g_be    = g_dm ? bus.dm_be : 4'h0;
                g_addr  = g_dm ? bus.dm_addr[AW+1:2] : bus.if_addr[AW+1:2];
                g_wdata = bus.dm_wdata;
                g_rdata = mem[g_addr];
            end
        end
    end

    always @(negedge clk) begin : cmp
        bit e_en, e_ia, e_da;
        e_en = rst && (cyc == g_cyc + 1);
        e_ia = rst && (cyc == g_cyc + LAT + 2) && !g_dm;
        e_da = rst && (cyc == g_cyc + LAT + 2) && g_dm;
        chk("m_mem_en", 32'(bus.mem_en), 32'(e_en));
        chk("m_mem_we", 32'(bus.mem_we), 32'(e_en && g_we));
        chk("m_mem_be", 32'(bus.mem_be), (e_en && g_dm) ? 32'(g_be) : 32'd0);
        if (e_en) begin
            chk("m_mem_addr", 32'(bus.mem_addr), 32'(g_addr));
            if (g_we) chk("m_mem_wdata", bus.mem_wdata, g_wdata);
        end
        chk("m_if_ack", 32'(bus.if_ack), 32'(e_ia));
        chk("m_dm_ack", 32'(bus.dm_ack), 32'(e_da));
        chk("m_if_rdata", bus.if_rdata, e_if_rd);
        if (dm_rd_known) chk("m_dm_rdata", bus.dm_rdata, e_dm_rd);
        chk("m_stall", 32'(bus.stall), 32'((bus.if_req && !e_ia) || (bus.dm_req && !e_da)));
    end

    task automatic nxt(); @(posedge clk); #1; endtask
    task automatic smp(); @(negedge clk); endtask

    // Counts cycles from the current (request) cycle to the ack; -1 if none within budget.
    task automatic wait_ack(input int sel, output int n);
        n = -1;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) nxt();
            smp();
            if ((sel == 0 && bus.if_ack) || (sel == 1 && bus.dm_ack) || (sel == 2 && bus3.if_ack)) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic idle_inputs();
        bus.if_req = 1'b0; bus.if_addr = '0; bus.dm_req = 1'b0; bus.dm_we = 1'b0;
        bus.dm_be = '0; bus.dm_addr = '0; bus.dm_wdata = '0;
        bus3.if_req = 1'b0; bus3.if_addr = '0; bus3.dm_req = 1'b0; bus3.dm_we = 1'b0;
        bus3.dm_be = '0; bus3.dm_addr = '0; bus3.dm_wdata = '0;
    endtask

    initial begin
        int    n;
        string order;
        idle_inputs();
        rst = 1'b0;
        repeat (4) begin
            nxt();
            bus.if_req = 1'($urandom); bus.dm_req = 1'($urandom); bus.dm_we = 1'($urandom);
            bus.if_addr = $urandom; bus.dm_addr = $urandom; bus.dm_be = 4'($urandom);
            bus.dm_wdata = $urandom;
            smp();
            chk("rst_mem_en", 32'(bus.mem_en), 0);
            chk("rst_mem_we", 32'(bus.mem_we), 0);
            chk("rst_mem_addr", 32'(bus.mem_addr), 0);
            chk("rst_acks", 32'({bus.if_ack, bus.dm_ack}), 0);
            chk("rst_rdata", bus.if_rdata | bus.dm_rdata, 0);
        end
        nxt(); idle_inputs(); rst = 1'b1;

        // Single fetch of word 2.
        nxt(); bus.if_req = 1'b1; bus.if_addr = 32'h8;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) nxt();
            smp();
            chk($sformatf("fetch_en_c%0d", k), 32'(bus.mem_en), 32'(k == 1));
            if (k == 1) chk("fetch_addr", 32'(bus.mem_addr), 2);
            chk($sformatf("fetch_ack_c%0d", k), 32'(bus.if_ack), 32'(k == 3));
            chk($sformatf("fetch_stall_c%0d", k), 32'(bus.stall), 32'(k < 3));
        end
        chk("fetch_rdata", bus.if_rdata, 32'h0050_0093);
        nxt(); bus.if_req = 1'b0;

        // Collision: data first, fetch after.
        nxt(); bus.if_req = 1'b1; bus.if_addr = 32'hC;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h10;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) nxt();
            if (k == 4) bus.dm_req = 1'b0;
            smp();
            chk($sformatf("coll_en_c%0d", k), 32'(bus.mem_en), 32'(k == 1 || k == 5));
            if (k == 1) chk("coll_daddr", 32'(bus.mem_addr), 4);
            if (k == 5) chk("coll_iaddr", 32'(bus.mem_addr), 3);
            chk($sformatf("coll_dack_c%0d", k), 32'(bus.dm_ack), 32'(k == 3));
            chk($sformatf("coll_iack_c%0d", k), 32'(bus.if_ack), 32'(k == 7));
            if (k == 3) chk("coll_drdata", bus.dm_rdata, 32'hD000_0004);
        end
        chk("coll_irdata", bus.if_rdata, 32'hD000_0003);
        nxt(); bus.if_req = 1'b0;

        // Store of one byte lane, then read the word back.
        nxt(); bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_be = 4'b0100;
        bus.dm_wdata = 32'h00AB_0000; bus.dm_addr = 32'h14;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) nxt();
            smp();
            chk($sformatf("st_we_c%0d", k), 32'(bus.mem_we), 32'(k == 1));
            if (k == 1) begin
                chk("st_be", 32'(bus.mem_be), 32'h4);
                chk("st_addr", 32'(bus.mem_addr), 5);
                chk("st_wdata", bus.mem_wdata, 32'h00AB_0000);
            end
            chk($sformatf("st_dack_c%0d", k), 32'(bus.dm_ack), 32'(k == 3));
            chk($sformatf("st_iack_c%0d", k), 32'(bus.if_ack), 0);
        end
        nxt(); bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_be = '0;
        nxt(); bus.dm_req = 1'b1; bus.dm_addr = 32'h14;
        wait_ack(1, n);
        chk("ld_latency", n, 3);
        chk("ld_rdata", bus.dm_rdata, 32'hD0AB_0005);
        nxt(); bus.dm_req = 1'b0;

        // Fetch held against a data requester that re-requests every IDLE.
        nxt(); bus.if_req = 1'b1; bus.if_addr = 32'h4;
        bus.dm_req = 1'b1; bus.dm_addr = 32'h18;
        order = "";
        for (int k = 0; k < 60 && order.len() < 6; k++) begin
            smp();
            if (bus.dm_ack) order = {order, "D"};
            if (bus.if_ack) order = {order, "I"};
            if (order.len() < 6) nxt();
        end
`ifdef ARB_FETCH_GUARD_EN
        chk_s("starve_order", order, "DDIDDI");
        nxt(); bus.if_req = 1'b0; bus.dm_req = 1'b0;
`else
        chk_s("starve_order", order, "DDDDDD");
        nxt(); bus.dm_req = 1'b0;
        wait_ack(0, n);
        chk("starve_release", n, 3);
        nxt(); bus.if_req = 1'b0;
`endif

        // Reset in the second WAIT cycle of a MEM_LAT=3 fetch.
        nxt(); bus3.if_req = 1'b1; bus3.if_addr = 32'hC;
        nxt();
        smp(); chk("r3_access", 32'(bus3.mem_en), 1);
        nxt();
        nxt(); rst = 1'b0; bus3.if_req = 1'b0;
        smp();
        chk("r3_rst_en", 32'(bus3.mem_en), 0);
        chk("r3_rst_addr", 32'(bus3.mem_addr), 0);
        chk("r3_rst_ack", 32'(bus3.if_ack), 0);
        chk("r3_rst_rdata", bus3.if_rdata, 0);
        nxt(); rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            smp(); chk($sformatf("r3_no_ack_%0d", k), 32'(bus3.if_ack), 0);
            nxt();
        end
        bus3.if_req = 1'b1; bus3.if_addr = 32'hC;
        wait_ack(2, n);
        chk("r3_latency", n, 5);
        chk("r3_rdata", bus3.if_rdata, 32'hA5A5_0003);
        nxt(); bus3.if_req = 1'b0;
        repeat (3) nxt();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish (checks %0d)", checks);
        $fatal(1);
    end
endmodule
